// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data memory with switch, LED and timer MMIO
//
// Purpose: word RAM with byte-lane writes plus a memory-mapped peripheral
// block (synchronised switches, LED register, optional compare timer) on the
// core's data port. Reads are combinational; writes commit on rising clk.
//
// Optional feature macro: DMEM_MMIO_TIMER_EN (timer registers, prescaler
// and irq). Without it the timer addresses read 0, ignore writes, irq = 0.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   nreset   in   1      asynchronous active-low reset
//   we       in   1      write enable
//   be       in   4      byte-lane enables (RAM writes only)
//   a        in   32     byte address
//   wd       in   32     write data
//   rd       out  32     combinational read data
//   switches in   SW_W   raw asynchronous switch inputs
//   leds     out  LED_W  LED register
//   irq      out  1      timer match flag (level)

module dmem_mmio #(
  parameter int DEPTH     = 64,
  parameter int SW_W      = 10,
  parameter int LED_W     = 10,
  parameter int PRESCALE  = 1,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      a,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [31:0] ADDR_SW  = 32'hC000_0000;
  localparam logic [31:0] ADDR_LED = 32'hC000_0004;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PRESCALE < 1) begin : g_param_check
    $error("dmem_mmio: DEPTH must be a power of 2 >= 4 and PRESCALE >= 1");
  end

  // ---------------------------------------------------------------- RAM
  logic [31:0]   mem_q [DEPTH];
  logic          ram_hit;
  logic [AW-1:0] ram_idx;

  // Any set bit above the RAM window makes the access unmapped, so high
  // addresses never alias onto low words.
  assign ram_hit = (a[31:AW+2] == '0);
  assign ram_idx = a[AW+1:2];

  // RAM is deliberately outside the reset domain so its contents survive nreset.
  always_ff @(posedge clk) begin
    if (we && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[ram_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------- switches and LEDs
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [LED_W-1:0] led_q, led_d;

  assign led_d = (we && a == ADDR_LED) ? wd[LED_W-1:0] : led_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
    end
  end

  assign leds = led_q;

`ifdef DMEM_MMIO_TIMER_EN
  // -------------------------------------------------------------- timer
  localparam logic [31:0] ADDR_TCNT = 32'hC000_0008;
  localparam logic [31:0] ADDR_TCMP = 32'hC000_000C;
  localparam logic [31:0] ADDR_TCTL = 32'hC000_0010;
  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pc_q, pc_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic [31:0]   tcmp_q, tcmp_d;
  logic          en_q, en_d;
  logic          ar_q, ar_d;
  logic          match_q, match_d;
  logic          tick, hit;
  logic          wr_tcnt, wr_tcmp, wr_tctl;

  assign wr_tcnt = we && (a == ADDR_TCNT);
  assign wr_tcmp = we && (a == ADDR_TCMP);
  assign wr_tctl = we && (a == ADDR_TCTL);

  always_comb begin
    tick    = en_q && (pc_q == PW'(PRESCALE - 1));
    hit     = tick && (tcnt_q == tcmp_q);
    pc_d    = pc_q;
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    en_d    = en_q;
    ar_d    = ar_q;
    match_d = match_q;

    if (!en_q || tick) pc_d = '0;
    else               pc_d = pc_q + 1'b1;
    // Disabling restarts the prescaler so a later enable gets a full period.
    if (wr_tctl && !wd[0]) pc_d = '0;

    if (tick) tcnt_d = (hit && ar_q) ? 32'd0 : tcnt_q + 32'd1;
    if (wr_tcnt) tcnt_d = wd;            // CPU write beats a same-cycle tick

    if (wr_tcmp) tcmp_d = wd;

    if (wr_tctl) begin
      en_d = wd[0];
      ar_d = wd[1];
      if (wd[8]) match_d = 1'b0;
    end
    if (hit) match_d = 1'b1;             // a new match beats a same-cycle clear
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_q    <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      match_q <= match_d;
    end
  end

  assign irq = match_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------- read mux
  always_comb begin
    rd = '0;
    case (a)
      ADDR_SW:   rd[SW_W-1:0]  = sw_sync_q;
      ADDR_LED:  rd[LED_W-1:0] = led_q;
`ifdef DMEM_MMIO_TIMER_EN
      ADDR_TCNT: rd = tcnt_q;
      ADDR_TCMP: rd = tcmp_q;
      ADDR_TCTL: rd = {23'd0, match_q, 6'd0, ar_q, en_q};
`endif
      default:   if (ram_hit) rd = mem_q[ram_idx];
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed self-checking bench for dmem_mmio

module tb_dmem_mmio;

  localparam logic [31:0] SW   = 32'hC000_0000;
  localparam logic [31:0] LED  = 32'hC000_0004;
  localparam logic [31:0] TCNT = 32'hC000_0008;
  localparam logic [31:0] TCMP = 32'hC000_000C;
  localparam logic [31:0] TCTL = 32'hC000_0010;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_mmio #(.DEPTH(64), .SW_W(10), .LED_W(10), .PRESCALE(4), .INIT_FILE("")) dut (
    .clk(clk), .nreset(nreset), .we(we), .be(be), .a(a), .wd(wd), .rd(rd),
    .switches(switches), .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called in the low clock phase: commits on the next rising edge and
  // returns at the following falling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] lanes);
    a = addr; wd = data; be = lanes; we = 1'b1;
    @(negedge clk);
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  initial begin
    #1 nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rdchk("rst_sw", SW, 32'h0);
    rdchk("rst_led_rd", LED, 32'h0);
    @(negedge clk);
    nreset = 1'b1;

    // RAM byte lanes
    wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h10, 32'h0000_00AA, 4'b0001);
    rdchk("ram_be0001", 32'h10, 32'hDEAD_BEAA);
    rdchk("ram_lowbits", 32'h13, 32'hDEAD_BEAA);
    wr(32'h10, 32'h0000_0000, 4'b0000);
    rdchk("ram_be0000", 32'h10, 32'hDEAD_BEAA);
    wr(32'h14, 32'h0000_0000, 4'b1111);
    wr(32'h14, 32'h1234_5678, 4'b0110);
    rdchk("ram_be0110", 32'h17, 32'h0034_5600);
    wr(32'h14, 32'hA5A5_A5A5, 4'b1000);
    rdchk("ram_be1000", 32'h14, 32'hA534_5600);
    wr(32'hFC, 32'hCAFE_F00D, 4'b1111);
    rdchk("ram_top", 32'hFC, 32'hCAFE_F00D);

    // Out-of-range RAM addresses must not alias
    wr(32'h0, 32'h1111_2222, 4'b1111);
    wr(32'h100, 32'hFFFF_FFFF, 4'b1111);
    rdchk("ram_oob_rd", 32'h100, 32'h0);
    rdchk("ram_oob_noalias", 32'h0, 32'h1111_2222);

    // Switch synchroniser: two edges of latency
    switches = 10'h2A5;
    rdchk("sw_edge0", SW, 32'h0);
    @(negedge clk);
    rdchk("sw_edge1", SW, 32'h0);
    @(negedge clk);
    rdchk("sw_edge2", SW, 32'h0000_02A5);
    wr(SW, 32'h0, 4'b1111);
    rdchk("sw_ro", SW, 32'h0000_02A5);

    // LED register and unmapped MMIO
    wr(LED, 32'h0000_03FF, 4'b0000);
    check("led_out", 32'(leds), 32'h3FF);
    rdchk("led_rd", LED, 32'h3FF);
    wr(32'hC000_0020, 32'h0, 4'b1111);
    check("unmapped_wr_led", 32'(leds), 32'h3FF);
    rdchk("unmapped_rd", 32'hC000_0020, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
    // PRESCALE=4, autoreload: 0,1,2,3 then match and reload
    wr(TCMP, 32'd3, 4'b1111);
    wr(TCTL, 32'h3, 4'b1111);
    rdchk("tm_start", TCNT, 32'd0);
    repeat (3) @(negedge clk);
    rdchk("tm_pre3", TCNT, 32'd0);
    @(negedge clk);
    rdchk("tm_tick1", TCNT, 32'd1);
    repeat (4) @(negedge clk);
    rdchk("tm_tick2", TCNT, 32'd2);
    repeat (4) @(negedge clk);
    rdchk("tm_tick3", TCNT, 32'd3);
    check("tm_noirq", 32'(irq), 32'h0);
    repeat (4) @(negedge clk);
    rdchk("tm_reload", TCNT, 32'd0);
    rdchk("tm_match", TCTL, 32'h103);
    check("tm_irq", 32'(irq), 32'h1);
    wr(TCTL, 32'h103, 4'b1111);
    rdchk("tm_w1c", TCTL, 32'h3);
    check("tm_w1c_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rdchk("tm_run_pre", TCNT, 32'd0);
    @(negedge clk);
    rdchk("tm_run", TCNT, 32'd1);
    wr(TCTL, 32'h100, 4'b1111);
    rdchk("tm_stop_ctl", TCTL, 32'h0);
    repeat (8) @(negedge clk);
    rdchk("tm_stop_hold", TCNT, 32'd1);

    // Match and W1C in the same cycle: set wins
    wr(TCMP, 32'd1, 4'b1111);
    rdchk("tcmp_no_tcnt", TCNT, 32'd1);
    rdchk("tcmp_no_match", TCTL, 32'h0);
    wr(TCTL, 32'h3, 4'b1111);
    repeat (3) @(negedge clk);
    wr(TCTL, 32'h103, 4'b1111);
    rdchk("w1c_vs_set", TCTL, 32'h103);
    check("w1c_vs_set_irq", 32'(irq), 32'h1);
    rdchk("w1c_vs_set_cnt", TCNT, 32'd0);

    // Wrap without autoreload, then write beating a tick
    wr(TCTL, 32'h100, 4'b1111);
    wr(TCNT, 32'hFFFF_FFFE, 4'b1111);
    wr(TCMP, 32'hFFFF_FFFF, 4'b1111);
    wr(TCTL, 32'h1, 4'b1111);
    repeat (4) @(negedge clk);
    rdchk("wrap_max", TCNT, 32'hFFFF_FFFF);
    check("wrap_max_irq", 32'(irq), 32'h0);
    repeat (4) @(negedge clk);
    rdchk("wrap_zero", TCNT, 32'h0);
    rdchk("wrap_match", TCTL, 32'h101);
    repeat (3) @(negedge clk);
    wr(TCNT, 32'h55, 4'b1111);
    rdchk("wr_beats_tick", TCNT, 32'h55);
    repeat (4) @(negedge clk);
    rdchk("after_wr_tick", TCNT, 32'h56);
    check("pre_rst_irq", 32'(irq), 32'h1);
`else
    wr(TCNT, 32'hFFFF_FFFF, 4'b1111);
    wr(TCMP, 32'hFFFF_FFFF, 4'b1111);
    wr(TCTL, 32'hFFFF_FFFF, 4'b1111);
    rdchk("notm_tcnt", TCNT, 32'h0);
    rdchk("notm_tcmp", TCMP, 32'h0);
    rdchk("notm_tctl", TCTL, 32'h0);
    check("notm_led", 32'(leds), 32'h3FF);
    repeat (20) @(negedge clk);
    check("notm_irq", 32'(irq), 32'h0);
    rdchk("notm_tcnt_late", TCNT, 32'h0);
`endif

    // Asynchronous reset mid-operation; RAM survives
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    rdchk("arst_sw", SW, 32'h0);
`ifdef DMEM_MMIO_TIMER_EN
    rdchk("arst_tcnt", TCNT, 32'h0);
    rdchk("arst_tctl", TCTL, 32'h0);
`endif
    rdchk("arst_ram10", 32'h10, 32'hDEAD_BEAA);
    rdchk("arst_ramfc", 32'hFC, 32'hCAFE_F00D);
    @(negedge clk);
    nreset = 1'b1;
    wr(LED, 32'h155, 4'b1111);
    check("post_rst_wr", 32'(leds), 32'h155);
    repeat (2) @(negedge clk);
    rdchk("post_rst_sw", SW, 32'h0000_02A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
